// File: rtl/mii_pkg.sv
// Shared MII code points, framer state encoding and keep-mask helper.
// The downstream checker imports the same codes so both ends agree on them.
package mii_pkg;

  localparam logic [7:0] IDLE_CODE  = 8'h07;
  localparam logic [7:0] START_CODE = 8'hFB;
  localparam logic [7:0] TERM_CODE  = 8'hFD;
  localparam logic [7:0] ERROR_CODE = 8'hFE;
  localparam logic [7:0] PREAMBLE   = 8'h55;
  localparam logic [7:0] SFD        = 8'hD5;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    TERM,
    DROP
  } framer_state_t;

  // Number of contiguous valid lanes starting at lane 0 (0..8).
  function automatic logic [3:0] keep_to_len(input logic [7:0] keep);
    logic [3:0] len;
    logic       run;
    len = 4'd0;
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (run && keep[i]) begin
        len = len + 4'd1;
      end else begin
        run = 1'b0;
      end
    end
    return len;
  endfunction

endpackage

// File: rtl/mii_term_encoder.sv
// Builds the final-word image for a partial last word: payload lanes below
// the keep boundary, TERM in the first empty lane, IDLE fill above it.
// Also qualifies the keep mask as a legal 2^n-1 pattern.
module mii_term_encoder
  import mii_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [CTRL_WIDTH-1:0] i_keep,
  output logic [DATA_WIDTH-1:0] o_term_data,
  output logic [CTRL_WIDTH-1:0] o_term_ctrl,
  output logic                  o_keep_ok,
  output logic [3:0]            o_len
);

  logic [CTRL_WIDTH-1:0] w_keep_inc;

  assign o_len      = keep_to_len(i_keep);
  assign w_keep_inc = i_keep + CTRL_WIDTH'(1);
  // A mask of the form 2^n-1 has no bit in common with itself plus one.
  assign o_keep_ok  = (i_keep != '0) && ((i_keep & w_keep_inc) == '0);

  for (genvar gi = 0; gi < CTRL_WIDTH; gi++) begin : g_lane
    assign o_term_data[gi*8 +: 8] = (4'(gi) < o_len)  ? i_data[gi*8 +: 8] :
                                    (4'(gi) == o_len) ? TERM_CODE : IDLE_CODE;
    assign o_term_ctrl[gi]        = (4'(gi) >= o_len);
  end

endmodule

// File: rtl/mii_tx_framer.sv
// Converts a valid/ready word stream into MII data/ctrl lanes: inserts the
// start word, TERM code and IDLE fill, enforces the minimum inter-frame gap
// and replaces malformed or underrun words with an error word.
module mii_tx_framer
  import mii_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int CTRL_WIDTH    = 8,
  parameter int MIN_IPG_BYTES = 12
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [CTRL_WIDTH-1:0] i_keep,
  input  logic                  i_last,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic [CTRL_WIDTH-1:0] o_tx_ctrl,
  output logic                  o_frame_done,
  output logic                  o_abort
);

  localparam int IPG_W = $clog2(MIN_IPG_BYTES + 8);
  localparam logic [IPG_W-1:0]      IPG_MIN    = IPG_W'(MIN_IPG_BYTES);
  localparam logic [CTRL_WIDTH-1:0] CTRL_ALL   = '1;
  localparam logic [CTRL_WIDTH-1:0] START_CTRL = CTRL_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] IDLE_WORD  = {CTRL_WIDTH{IDLE_CODE}};
  localparam logic [DATA_WIDTH-1:0] ERROR_WORD = {CTRL_WIDTH{ERROR_CODE}};
  localparam logic [DATA_WIDTH-1:0] TERM_WORD  = {{(CTRL_WIDTH-1){IDLE_CODE}}, TERM_CODE};
  localparam logic [DATA_WIDTH-1:0] START_WORD = {SFD, {(CTRL_WIDTH-2){PREAMBLE}}, START_CODE};

  framer_state_t         r_state;
  framer_state_t         w_state_next;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic [DATA_WIDTH-1:0] w_tx_data;
  logic [CTRL_WIDTH-1:0] r_tx_ctrl;
  logic [CTRL_WIDTH-1:0] w_tx_ctrl;
  logic                  r_frame_done;
  logic                  w_frame_done;
  logic                  r_abort;
  logic                  w_abort;
  logic [IPG_W-1:0]      r_ipg_cnt;
  logic [IPG_W-1:0]      w_ipg_next;
  logic [IPG_W:0]        w_ipg_sum;
  logic [IPG_W-1:0]      w_ipg_idle;
  logic                  w_gap_ok;

  logic [DATA_WIDTH-1:0] w_term_data;
  logic [CTRL_WIDTH-1:0] w_term_ctrl;
  logic                  w_keep_ok;
  logic [3:0]            w_len;

  mii_term_encoder #(
    .DATA_WIDTH (DATA_WIDTH),
    .CTRL_WIDTH (CTRL_WIDTH)
  ) u_term_encoder (
    .i_data      (i_data),
    .i_keep      (i_keep),
    .o_term_data (w_term_data),
    .o_term_ctrl (w_term_ctrl),
    .o_keep_ok   (w_keep_ok),
    .o_len       (w_len)
  );

  // Gap count including the idle word emitted this cycle, saturated at the
  // minimum; the start decision uses it so the idle word being loaded now
  // already counts towards the gap.
  assign w_ipg_sum  = {1'b0, r_ipg_cnt} + (IPG_W + 1)'(8);
  assign w_ipg_idle = (w_ipg_sum >= {1'b0, IPG_MIN}) ? IPG_MIN : w_ipg_sum[IPG_W-1:0];
  assign w_gap_ok   = (w_ipg_idle == IPG_MIN);

  assign o_ready      = (r_state == DATA) || (r_state == DROP);
  assign o_tx_data    = r_tx_data;
  assign o_tx_ctrl    = r_tx_ctrl;
  assign o_frame_done = r_frame_done;
  assign o_abort      = r_abort;

  // Next-state and next output word selection.
  always_comb begin
    w_state_next = r_state;
    w_tx_data    = IDLE_WORD;
    w_tx_ctrl    = CTRL_ALL;
    w_frame_done = 1'b0;
    w_abort      = 1'b0;
    w_ipg_next   = r_ipg_cnt;
    case (r_state)
      IDLE: begin
        w_ipg_next = w_ipg_idle;
        if (i_valid && w_gap_ok) begin
          w_state_next = START;
        end
      end
      START: begin
        w_tx_data    = START_WORD;
        w_tx_ctrl    = START_CTRL;
        w_state_next = DATA;
      end
      DATA: begin
        if (i_valid && !i_last && (i_keep == CTRL_ALL)) begin
          w_tx_data = i_data;
          w_tx_ctrl = '0;
        end else if (i_valid && i_last && (i_keep == CTRL_ALL)) begin
          // Full last word: TERM goes into the following word.
          w_tx_data    = i_data;
          w_tx_ctrl    = '0;
          w_state_next = TERM;
        end else if (i_valid && i_last && w_keep_ok) begin
          // Partial last word: TERM shares this word; its idle tail starts the gap.
          w_tx_data    = w_term_data;
          w_tx_ctrl    = w_term_ctrl;
          w_frame_done = 1'b1;
          w_ipg_next   = IPG_W'(4'd7 - w_len);
          w_state_next = IDLE;
        end else begin
          w_tx_data    = ERROR_WORD;
          w_tx_ctrl    = CTRL_ALL;
          w_abort      = 1'b1;
          w_ipg_next   = '0;
          w_state_next = (i_valid && i_last) ? IDLE : DROP;
        end
      end
      TERM: begin
        w_tx_data    = TERM_WORD;
        w_tx_ctrl    = CTRL_ALL;
        w_frame_done = 1'b1;
        w_ipg_next   = IPG_W'(7);
        w_state_next = IDLE;
      end
      DROP: begin
        w_ipg_next = w_ipg_idle;
        if (i_valid && i_last) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State, gap counter and registered MII outputs.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_tx_data    <= IDLE_WORD;
      r_tx_ctrl    <= CTRL_ALL;
      r_frame_done <= 1'b0;
      r_abort      <= 1'b0;
      r_ipg_cnt    <= IPG_MIN;
    end else begin
      r_state      <= w_state_next;
      r_tx_data    <= w_tx_data;
      r_tx_ctrl    <= w_tx_ctrl;
      r_frame_done <= w_frame_done;
      r_abort      <= w_abort;
      r_ipg_cnt    <= w_ipg_next;
    end
  end

endmodule

// File: tb/tb_mii_tx_framer.sv
// Directed bench for mii_tx_framer: drives frames through the valid/ready
// port, captures the MII lane stream and checks it against hand-built words.
module tb_mii_tx_framer;

  localparam logic [63:0] W_IDLE  = 64'h0707070707070707;
  localparam logic [63:0] W_START = 64'hD5555555555555FB;
  localparam logic [63:0] W_TERM  = 64'h07070707070707FD;
  localparam logic [63:0] W_ERR   = 64'hFEFEFEFEFEFEFEFE;

  logic        clk;
  logic        i_rst;
  logic        i_valid;
  logic [63:0] i_data;
  logic [7:0]  i_keep;
  logic        i_last;
  logic        o_ready;
  logic [63:0] o_tx_data;
  logic [7:0]  o_tx_ctrl;
  logic        o_frame_done;
  logic        o_abort;

  mii_tx_framer dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .i_keep       (i_keep),
    .i_last       (i_last),
    .o_ready      (o_ready),
    .o_tx_data    (o_tx_data),
    .o_tx_ctrl    (o_tx_ctrl),
    .o_frame_done (o_frame_done),
    .o_abort      (o_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  c;
    logic        fd;
    logic        ab;
  } rec_t;

  rec_t q[$];
  logic mon_en = 1'b0;
  int   n_cmp  = 0;
  int   n_err  = 0;

  // Capture the output lanes mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) q.push_back({o_tx_data, o_tx_ctrl, o_frame_done, o_abort});
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int f, input int w);
    logic [63:0] r;
    for (int l = 0; l < 8; l++) r[l*8 +: 8] = 8'(f * 32 + w * 8 + l);
    return r;
  endfunction

  function automatic int find_start(input int from);
    for (int i = from; i < q.size(); i++) begin
      if (i >= 0 && q[i].c == 8'h01 && q[i].d == W_START) return i;
    end
    return -1;
  endfunction

  task automatic chk_word(input string tag, input int idx, input logic [63:0] d,
                          input logic [7:0] c, input logic fd, input logic ab);
    logic [79:0] exp;
    exp = {6'b0, fd, ab, c, d};
    if (idx >= 0 && idx < q.size())
      check(tag, {6'b0, q[idx].fd, q[idx].ab, q[idx].c, q[idx].d}, exp);
    else
      check(tag, 'x, exp);
  endtask

  task automatic push_word(input logic [63:0] d, input logic [7:0] k, input logic last);
    int n;
    i_valid = 1'b1;
    i_data  = d;
    i_keep  = k;
    i_last  = last;
    n = 0;
    @(negedge clk);
    while (!o_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!o_ready) check("ready_timeout", 80'(o_ready), 80'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int f, input int n, input logic [7:0] last_keep,
                            input int bad_idx, input logic [7:0] bad_keep);
    logic [7:0] k;
    for (int w = 0; w < n; w++) begin
      k = (w == bad_idx) ? bad_keep : ((w == n - 1) ? last_keep : 8'hFF);
      push_word(pat(f, w), k, (w == n - 1));
    end
    $display("frame %0d: %0d words handed over, last keep %h", f, n, last_keep);
  endtask

  task automatic idle_cycles(input int n);
    i_valid = 1'b0;
    i_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int sA, sB, sC, sD, sE, sF, sG, sH, sI, sK, nfd, nab;
    logic [63:0] p;

    i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_keep = '0; i_last = 1'b0;
    #1;
    check("rst_data",  80'(o_tx_data), 80'(W_IDLE));
    check("rst_ctrl",  80'(o_tx_ctrl), 80'(8'hFF));
    check("rst_ready", 80'(o_ready), 80'(0));
    check("rst_pulses", 80'({o_frame_done, o_abort}), 80'(0));
    repeat (3) @(posedge clk);
    #1;
    i_rst  = 1'b0;
    mon_en = 1'b1;

    // Legal frames: partial, full, 7-lane and short, valid held between them.
    send_frame(1, 5, 8'h0F, -1, 8'h00);
    send_frame(2, 5, 8'hFF, -1, 8'h00);
    send_frame(3, 5, 8'h7F, -1, 8'h00);
    send_frame(4, 2, 8'hFF, -1, 8'h00);
    idle_cycles(4);
    // Underrun mid-frame, remainder drained in DROP.
    push_word(pat(5, 0), 8'hFF, 1'b0);
    push_word(pat(5, 1), 8'hFF, 1'b0);
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    push_word(pat(5, 2), 8'hFF, 1'b0);
    push_word(pat(5, 3), 8'hFF, 1'b1);
    $display("frame 5: underrun after 2 words, 2 words drained");
    send_frame(6, 3, 8'hFF, -1, 8'h00);
    send_frame(7, 3, 8'hFF, 1, 8'h0F);
    send_frame(8, 2, 8'h05, -1, 8'h00);
    send_frame(9, 2, 8'hFF, -1, 8'h00);
    idle_cycles(10);
    mon_en = 1'b0;

    sA = find_start(0);
    chk_word("A_start", sA, W_START, 8'h01, 1'b0, 1'b0);
    for (int w = 0; w < 4; w++) chk_word($sformatf("A_d%0d", w), sA + 1 + w, pat(1, w), 8'h00, 1'b0, 1'b0);
    p = pat(1, 4);
    chk_word("A_term", sA + 5, {8'h07, 8'h07, 8'h07, 8'hFD, p[31:0]}, 8'hF0, 1'b1, 1'b0);
    chk_word("A_idle0", sA + 6, W_IDLE, 8'hFF, 1'b0, 1'b0);
    chk_word("A_idle1", sA + 7, W_IDLE, 8'hFF, 1'b0, 1'b0);
    sB = find_start(sA + 1);
    check("A_gap_pos", 80'(sB), 80'(sA + 8));

    for (int w = 0; w < 5; w++) chk_word($sformatf("B_d%0d", w), sB + 1 + w, pat(2, w), 8'h00, 1'b0, 1'b0);
    chk_word("B_term", sB + 6, W_TERM, 8'hFF, 1'b1, 1'b0);
    chk_word("B_idle0", sB + 7, W_IDLE, 8'hFF, 1'b0, 1'b0);
    sC = find_start(sB + 1);
    check("B_gap_pos", 80'(sC), 80'(sB + 8));

    for (int w = 0; w < 4; w++) chk_word($sformatf("C_d%0d", w), sC + 1 + w, pat(3, w), 8'h00, 1'b0, 1'b0);
    p = pat(3, 4);
    chk_word("C_term", sC + 5, {8'hFD, p[55:0]}, 8'h80, 1'b1, 1'b0);
    chk_word("C_idle0", sC + 6, W_IDLE, 8'hFF, 1'b0, 1'b0);
    chk_word("C_idle1", sC + 7, W_IDLE, 8'hFF, 1'b0, 1'b0);
    sD = find_start(sC + 1);
    check("C_gap_pos", 80'(sD), 80'(sC + 8));

    chk_word("D_d0", sD + 1, pat(4, 0), 8'h00, 1'b0, 1'b0);
    chk_word("D_d1", sD + 2, pat(4, 1), 8'h00, 1'b0, 1'b0);
    chk_word("D_term", sD + 3, W_TERM, 8'hFF, 1'b1, 1'b0);
    chk_word("D_idle0", sD + 4, W_IDLE, 8'hFF, 1'b0, 1'b0);

    sE = find_start(sD + 1);
    chk_word("E_d1", sE + 2, pat(5, 1), 8'h00, 1'b0, 1'b0);
    chk_word("E_err", sE + 3, W_ERR, 8'hFF, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) chk_word($sformatf("E_drop%0d", i), sE + 4 + i, W_IDLE, 8'hFF, 1'b0, 1'b0);
    sF = find_start(sE + 1);
    check("E_gap_pos", 80'(sF), 80'(sE + 7));

    chk_word("F_d2", sF + 3, pat(6, 2), 8'h00, 1'b0, 1'b0);
    chk_word("F_term", sF + 4, W_TERM, 8'hFF, 1'b1, 1'b0);
    sG = find_start(sF + 1);
    check("F_gap_pos", 80'(sG), 80'(sF + 6));

    chk_word("G_d0", sG + 1, pat(7, 0), 8'h00, 1'b0, 1'b0);
    chk_word("G_err", sG + 2, W_ERR, 8'hFF, 1'b0, 1'b1);
    chk_word("G_drop", sG + 3, W_IDLE, 8'hFF, 1'b0, 1'b0);
    sH = find_start(sG + 1);
    check("G_gap_pos", 80'(sH), 80'(sG + 5));

    chk_word("H_d0", sH + 1, pat(8, 0), 8'h00, 1'b0, 1'b0);
    chk_word("H_err", sH + 2, W_ERR, 8'hFF, 1'b0, 1'b1);
    chk_word("H_idle0", sH + 3, W_IDLE, 8'hFF, 1'b0, 1'b0);
    sI = find_start(sH + 1);
    check("H_gap_pos", 80'(sI), 80'(sH + 5));

    chk_word("I_d1", sI + 2, pat(9, 1), 8'h00, 1'b0, 1'b0);
    chk_word("I_term", sI + 3, W_TERM, 8'hFF, 1'b1, 1'b0);

    nfd = 0;
    nab = 0;
    foreach (q[i]) begin
      nfd += int'(q[i].fd);
      nab += int'(q[i].ab);
    end
    check("frame_done_total", 80'(nfd), 80'(6));
    check("abort_total", 80'(nab), 80'(3));

    // Reset while in DATA: outputs return to idle at once, no TERM emitted.
    push_word(pat(10, 0), 8'hFF, 1'b0);
    push_word(pat(10, 1), 8'hFF, 1'b0);
    i_valid = 1'b0;
    #2;
    i_rst = 1'b1;
    #1;
    check("midrst_data", 80'(o_tx_data), 80'(W_IDLE));
    check("midrst_ctrl", 80'(o_tx_ctrl), 80'(8'hFF));
    check("midrst_ready", 80'(o_ready), 80'(0));
    $display("frame 10: reset asserted after 2 words");
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    q.delete();
    mon_en = 1'b1;
    send_frame(11, 3, 8'h3F, -1, 8'h00);
    idle_cycles(4);
    mon_en = 1'b0;
    chk_word("K_q0", 0, W_IDLE, 8'hFF, 1'b0, 1'b0);
    sK = find_start(0);
    check("K_start_lat", 80'(sK), 80'(2));
    chk_word("K_d0", sK + 1, pat(11, 0), 8'h00, 1'b0, 1'b0);
    p = pat(11, 2);
    chk_word("K_term", sK + 3, {8'h07, 8'hFD, p[47:0]}, 8'hC0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
